hilo_muldiv: RTL and testbench

Iterative unsigned multiply/divide unit that owns the architectural HI and LO registers. It executes MULTU and DIVU one bit per cycle and performs MTHI/MTLO writes. Its `hi`/`lo` outputs feed the 32-bit move-select mux in write-back, which picks them for MFHI/MFLO.

---
 rtl/hilo_pkg.sv | 20 ++
 rtl/hilo_step.sv | 33 +++
 rtl/hilo_muldiv.sv | 115 +++++++++++
 tb/tb_hilo_muldiv.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM states and default sizing.
package hilo_pkg;

  localparam int HILO_WIDTH = 32;
  localparam int CNT_W      = $clog2(HILO_WIDTH + 1);

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIN  = 2'b11
  } state_t;

endpackage

// File: rtl/hilo_step.sv
// One iteration of the shift-add multiplier or restoring divider over the
// shared 2*WIDTH working register {upper, lower}.
module hilo_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] work,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] work_nxt
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shifted;
  logic [WIDTH:0]   div_diff;
  logic             q_bit;
  logic [WIDTH-1:0] div_rem;

  always_comb begin
    // Multiply: upper half accumulates; carry drops back in on the right shift.
    mul_sum = {1'b0, work[2*WIDTH-1:WIDTH]} +
              (work[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

    // Divide: upper = partial remainder, lower = dividend bits becoming quotient.
    div_shifted = work[2*WIDTH-1:WIDTH-1];
    div_diff    = div_shifted - {1'b0, opnd};
    q_bit       = ~div_diff[WIDTH];
    div_rem     = q_bit ? div_diff[WIDTH-1:0] : div_shifted[WIDTH-1:0];

    if (is_div) work_nxt = {div_rem, work[WIDTH-2:0], q_bit};
    else        work_nxt = {mul_sum, work[WIDTH-1:1]};
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative unsigned MULTU/DIVU unit owning the architectural HI/LO registers;
// also performs MTHI/MTLO writes.
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: start/op/rs_val/rt_val are sampled on a rising edge only while
  // idle; a MULTU/DIVU raises busy the next cycle and ends with a one-cycle
  // done as HI/LO update. MTHI/MTLO complete at the sampling edge. Requests
  // while busy are dropped, not queued.
  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_inc;
  logic [2*WIDTH-1:0] work;
  logic [2*WIDTH-1:0] work_nxt;
  logic [WIDTH-1:0]   opnd;
  logic               accept_mul, accept_div, wr_hi, wr_lo, step_en, fin_load;

  assign cnt_inc   = cnt + 1'b1;
  assign dbg_state = state;

  hilo_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (state == ST_DIV),
    .work     (work),
    .opnd     (opnd),
    .work_nxt (work_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept_mul = 1'b0;
    accept_div = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    step_en    = 1'b0;
    fin_load   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULTU: begin accept_mul = 1'b1; state_nxt = ST_MUL; end
            OP_DIVU:  begin accept_div = 1'b1; state_nxt = ST_DIV; end
            OP_MTHI:  wr_hi = 1'b1;
            default:  wr_lo = 1'b1;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        step_en = 1'b1;
        if (cnt_inc == CW'(WIDTH)) begin
          fin_load  = 1'b1;
          state_nxt = ST_FIN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // HI/LO only change on the FIN entry edge or an MTHI/MTLO; the working
  // register carries all intermediate values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      work <= '0;
      opnd <= '0;
      hi   <= '0;
      lo   <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      if (accept_mul) begin
        work <= {{WIDTH{1'b0}}, rt_val};
        opnd <= rs_val;
        cnt  <= '0;
      end else if (accept_div) begin
        work <= {{WIDTH{1'b0}}, rs_val};
        opnd <= rt_val;
        cnt  <= '0;
      end else if (step_en) begin
        work <= work_nxt;
        cnt  <= cnt_inc;
      end
      if (fin_load) begin
        hi <= work_nxt[2*WIDTH-1:WIDTH];
        lo <= work_nxt[WIDTH-1:0];
      end
      if (wr_hi) hi <= rs_val;
      if (wr_lo) lo <= rs_val;
      busy <= (state_nxt != ST_IDLE);
      done <= (state_nxt == ST_FIN);
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: latency, results, MTHI/MTLO, ignored
// requests while busy and reset abort.
module tb_hilo_muldiv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue MULTU/DIVU, watch for done at cycle 33, and compare against the
  // scoreboard. meddle=1 injects ignored requests and operand changes.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e_hi,
                        input logic [31:0] e_lo, input bit meddle);
    int k;
    bit seen;
    logic [63:0] e;
    exp_q.push_back({e_hi, e_lo});
    seen = 0;
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1)  check({tag, "_busy1"}, {63'd0, busy}, 64'd1);
      if (k == 10) check({tag, "_hold"}, {hi, lo}, {m_hi, m_lo});
      if (done) begin
        seen = 1;
        check({tag, "_lat"}, 64'(k), 64'd33);
        check({tag, "_busyfin"}, {63'd0, busy}, 64'd1);
        e = exp_q.pop_front();
        check({tag, "_res"}, {hi, lo}, e);
        break;
      end
      if (meddle) begin
        if (k == 3) begin rs_val = $urandom_range(100, 1000); rt_val = $urandom_range(5, 50); end
        if (k == 5) begin start = 1'b1; op = 2'b10; rs_val = 32'h0000_DEAD; end
        if (k == 6) begin op = 2'b01; rs_val = 32'd9; rt_val = 32'd3; end
        if (k == 8) start = 1'b0;
      end
      @(posedge clk); #1;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      void'(exp_q.pop_front());
    end
    start = 1'b0;
    m_hi = e_hi; m_lo = e_lo;
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
  endtask

  task automatic mt(input string tag, input logic [1:0] o, input logic [31:0] v);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = v; rt_val = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    if (o == 2'b10) m_hi = v; else m_lo = v;
    @(negedge clk);
    check({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
    check({tag, "_bd"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);

    run_op("mul_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("div_100_7", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    run_op("div_msb_1", 2'b01, 32'h8000_0000, 32'd1, 32'd0, 32'h8000_0000, 0);
    run_op("div_by0", 2'b01, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0);

    mt("mthi", 2'b10, 32'hAAAA_AAAA);
    mt("mtlo", 2'b11, 32'h1234_5678);

    run_op("mul_meddle", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1);

    // Reset abort in the middle of a DIVU.
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_val = 32'd1000; rt_val = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_bd", {62'd0, busy, done}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_still_idle", {62'd0, busy, done}, 64'd0);

    run_op("mul_2_3", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule
